// File: rtl/seg_display_scanner.sv
// Multiplexed common-anode 7-segment scanner: clip number on the rightmost digit,
// mode letter on the leftmost, with ghost blanking, per-frame status snapshot and record blink.
module seg_display_scanner #(
  parameter int NUM_DIGITS   = 8,
  parameter int CLIP_BITS    = 3,
  parameter int SCAN_DIV     = 16,
  parameter int BLANK_CYCLES = 1,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  play,
  input  logic                  record,
  input  logic [CLIP_BITS-1:0]  clip_play_num,
  input  logic [CLIP_BITS-1:0]  clip_rec_num,
  output logic [6:0]            cathode,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  frame_start
);

  localparam int PRESC_W = $clog2(SCAN_DIV);
  localparam int DIGIT_W = $clog2(NUM_DIGITS);
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_PLAY = 2'd1;
  localparam logic [1:0] MODE_REC  = 2'd2;

  localparam logic [6:0] SEG_P     = 7'b0011000;
  localparam logic [6:0] SEG_R     = 7'b1111010;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [PRESC_W-1:0]   presc;
  logic [DIGIT_W-1:0]   digit;
  logic [FRAME_W-1:0]   frame_cnt;
  logic                 blink;
  logic [1:0]           snap_mode;
  logic [CLIP_BITS-1:0] snap_clip;

  logic                 slot_end;
  logic                 frame_end;
  logic                 snap_now;
  logic [1:0]           new_mode;
  logic [CLIP_BITS-1:0] new_clip;
  logic [1:0]           cur_mode;
  logic [CLIP_BITS-1:0] cur_clip;
  logic [NUM_DIGITS-1:0] anode_next;
  logic [6:0]           cathode_next;

  function automatic logic [6:0] digit_glyph(input logic [3:0] n);
    case (n)
      4'd1:    digit_glyph = 7'b1001111;
      4'd2:    digit_glyph = 7'b0010010;
      4'd3:    digit_glyph = 7'b0000110;
      4'd4:    digit_glyph = 7'b1001100;
      4'd5:    digit_glyph = 7'b0100100;
      4'd6:    digit_glyph = 7'b0100000;
      4'd7:    digit_glyph = 7'b0001111;
      4'd8:    digit_glyph = 7'b0000000;
      default: digit_glyph = SEG_BLANK;
    endcase
  endfunction

  assign slot_end  = (presc == PRESC_W'(SCAN_DIV - 1));
  assign frame_end = slot_end && (digit == DIGIT_W'(NUM_DIGITS - 1));
  assign snap_now  = (presc == '0) && (digit == '0);

  // The snapshot cycle already displays the freshly sampled status, so digit 0 never shows a stale slot.
  always_comb begin
    new_mode = MODE_IDLE;
    new_clip = '0;
    if (record) begin
      new_mode = MODE_REC;
      new_clip = clip_rec_num;
    end else if (play) begin
      new_mode = MODE_PLAY;
      new_clip = clip_play_num;
    end
    cur_mode = snap_now ? new_mode : snap_mode;
    cur_clip = snap_now ? new_clip : snap_clip;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc     <= '0;
      digit     <= '0;
      frame_cnt <= '0;
      blink     <= 1'b0;
      snap_mode <= MODE_IDLE;
      snap_clip <= '0;
    end else begin
      presc <= slot_end ? '0 : presc + 1'b1;
      if (slot_end)
        digit <= (digit == DIGIT_W'(NUM_DIGITS - 1)) ? '0 : digit + 1'b1;
      if (frame_end) begin
        if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink     <= ~blink;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
      if (snap_now) begin
        snap_mode <= new_mode;
        snap_clip <= new_clip;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++)
      anode_next[i] = (presc < PRESC_W'(BLANK_CYCLES)) || (digit != DIGIT_W'(i));
    cathode_next = SEG_BLANK;
    if (digit == '0) begin
      if (cur_mode != MODE_IDLE && !(cur_mode == MODE_REC && blink))
        cathode_next = digit_glyph(4'(cur_clip) + 4'd1);
    end else if (digit == DIGIT_W'(NUM_DIGITS - 1)) begin
      case (cur_mode)
        MODE_PLAY: cathode_next = SEG_P;
        MODE_REC:  cathode_next = SEG_R;
        default:   cathode_next = SEG_DASH;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      anode       <= '1;
      cathode     <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      anode       <= anode_next;
      cathode     <= cathode_next;
      frame_start <= snap_now;
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Scoreboard bench: stimulus pushes per-frame expected digit contents, monitors check whole frames.
module tb_seg_display_scanner;

  logic       clock = 1'b0;
  logic       reset;
  logic       play;
  logic       record;
  logic [2:0] clip_play_num;
  logic [2:0] clip_rec_num;
  logic [6:0] cathode;
  logic [7:0] anode;
  logic       frame_start;

  logic       play_b = 1'b1;
  logic       record_b = 1'b0;
  logic [2:0] clip_play_b = 3'd7;
  logic [2:0] clip_rec_b = 3'd0;
  logic [6:0] cathode_b;
  logic [3:0] anode_b;
  logic       frame_start_b;

  int checks = 0;
  int fails = 0;

  typedef struct { logic [6:0] d0; logic [6:0] dl; } frame_exp_t;
  typedef struct {
    logic p; logic r; logic [2:0] cp; logic [2:0] cr; bit glitch;
    logic [6:0] d0; logic [6:0] dl;
  } vec_t;

  frame_exp_t exp_q[$];
  vec_t       vecs[16];
  bit scan_go = 1'b0;
  bit mon_done = 1'b0;
  bit mon_b_done = 1'b0;

  localparam int NUM_FRAMES = 17;

  always #5 clock = ~clock;

  seg_display_scanner #(
    .NUM_DIGITS(8), .CLIP_BITS(3), .SCAN_DIV(4), .BLANK_CYCLES(1), .BLINK_FRAMES(2)
  ) dut (
    .clock(clock), .reset(reset), .play(play), .record(record),
    .clip_play_num(clip_play_num), .clip_rec_num(clip_rec_num),
    .cathode(cathode), .anode(anode), .frame_start(frame_start)
  );

  seg_display_scanner #(
    .NUM_DIGITS(4), .CLIP_BITS(3), .SCAN_DIV(4), .BLANK_CYCLES(1), .BLINK_FRAMES(64)
  ) dut_b (
    .clock(clock), .reset(reset), .play(play_b), .record(record_b),
    .clip_play_num(clip_play_b), .clip_rec_num(clip_rec_b),
    .cathode(cathode_b), .anode(anode_b), .frame_start(frame_start_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      fails++;
      $display("[TB] FAIL %s: actual %h, required %h", name, actual, required);
    end
  endtask

  // Called just after a mid-frame edge; inputs land in the next frame's snapshot.
  task automatic applyStimulus(input vec_t v);
    play = v.p;
    record = v.r;
    clip_play_num = v.cp;
    clip_rec_num = v.cr;
    exp_q.push_back('{v.d0, v.dl});
    if (v.glitch) begin
      repeat (3) @(posedge clock);
      #1;
      play = !v.p;
      record = !v.r;
      clip_play_num = v.cp + 3'd1;
      repeat (3) @(posedge clock);
      #1;
      play = v.p;
      record = v.r;
      clip_play_num = v.cp;
      repeat (26) @(posedge clock);
    end else begin
      repeat (32) @(posedge clock);
    end
    #1;
  endtask

  initial begin : main
    vecs[0]  = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 7'b1111111, 7'b1111110};
    vecs[1]  = '{1'b1, 1'b0, 3'd1, 3'd0, 1'b0, 7'b0010010, 7'b0011000};
    vecs[2]  = '{1'b1, 1'b1, 3'd5, 3'd0, 1'b0, 7'b1111111, 7'b1111010};
    vecs[3]  = '{1'b1, 1'b1, 3'd5, 3'd0, 1'b0, 7'b1001111, 7'b1111010};
    vecs[4]  = '{1'b1, 1'b1, 3'd5, 3'd0, 1'b0, 7'b1001111, 7'b1111010};
    vecs[5]  = '{1'b1, 1'b1, 3'd5, 3'd0, 1'b0, 7'b1111111, 7'b1111010};
    vecs[6]  = '{1'b1, 1'b0, 3'd7, 3'd0, 1'b0, 7'b0000000, 7'b0011000};
    vecs[7]  = '{1'b0, 1'b0, 3'd2, 3'd0, 1'b0, 7'b1111111, 7'b1111110};
    vecs[8]  = '{1'b0, 1'b0, 3'd2, 3'd0, 1'b1, 7'b1111111, 7'b1111110};
    vecs[9]  = '{1'b1, 1'b0, 3'd3, 3'd0, 1'b1, 7'b1001100, 7'b0011000};
    vecs[10] = '{1'b0, 1'b1, 3'd0, 3'd6, 1'b0, 7'b1111111, 7'b1111010};
    vecs[11] = '{1'b0, 1'b1, 3'd0, 3'd6, 1'b0, 7'b0001111, 7'b1111010};
    vecs[12] = '{1'b1, 1'b0, 3'd4, 3'd0, 1'b0, 7'b0100100, 7'b0011000};
    vecs[13] = '{1'b1, 1'b0, 3'd5, 3'd0, 1'b0, 7'b0100000, 7'b0011000};
    vecs[14] = '{1'b1, 1'b0, 3'd2, 3'd0, 1'b0, 7'b0000110, 7'b0011000};
    vecs[15] = '{1'b0, 1'b1, 3'd0, 3'd2, 1'b0, 7'b0000110, 7'b1111010};

    reset = 1'b1;
    play = 1'b0;
    record = 1'b0;
    clip_play_num = 3'd0;
    clip_rec_num = 3'd0;
    #2;
    checkOutput("reset_anode", 32'(anode), 32'h0FF);
    checkOutput("reset_cathode", 32'(cathode), 32'h07F);
    checkOutput("reset_frame_start", 32'(frame_start), 32'h0);
    checkOutput("reset_anode_b", 32'(anode_b), 32'h00F);

    @(posedge clock);
    #1 reset = 1'b0;
    repeat (30) @(posedge clock);
    #3;
    checkOutput("pre_reset_anode", 32'(anode), 32'h07F);
    checkOutput("pre_reset_cathode", 32'(cathode), 32'h07E);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_anode", 32'(anode), 32'h0FF);
    checkOutput("async_reset_cathode", 32'(cathode), 32'h07F);

    // Reset is held through one more edge, then the first frame pulse follows the next edge.
    exp_q.push_back('{7'b1111111, 7'b1111110});
    scan_go = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("frame_start_before_edge", 32'(frame_start), 32'h0);
    repeat (17) @(posedge clock);
    #1;
    for (int i = 0; i < 16; i++) applyStimulus(vecs[i]);

    for (int g = 0; g < 2000 && !(mon_done && mon_b_done); g++) @(posedge clock);
    if (!(mon_done && mon_b_done)) checkOutput("monitor_timeout", 32'h0, 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin : monitor
    frame_exp_t e;
    logic [7:0] exp_an;
    logic [6:0] exp_c;
    logic [6:0] d0_seen;
    logic [6:0] dl_seen;
    int an_bad;
    int fs_bad;
    int mid_bad;
    int guard;
    wait (scan_go);
    guard = 0;
    @(negedge clock);
    while (!frame_start && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (!frame_start) begin
      checkOutput("first_frame_start", 32'h0, 32'h1);
    end else begin
      for (int f = 0; f < NUM_FRAMES; f++) begin
        if (exp_q.size() == 0) begin
          checkOutput($sformatf("frame%0d_queue", f), 32'h0, 32'h1);
          e = '{7'b1111111, 7'b1111110};
        end else begin
          e = exp_q.pop_front();
        end
        an_bad = 0;
        fs_bad = 0;
        mid_bad = 0;
        d0_seen = e.d0;
        dl_seen = e.dl;
        for (int k = 0; k < 32; k++) begin
          exp_an = ((k % 4) < 1) ? 8'hFF : ~(8'h01 << (k / 4));
          if (anode !== exp_an) an_bad++;
          if (frame_start !== (k == 0)) fs_bad++;
          if ((k % 4) >= 1) begin
            exp_c = ((k / 4) == 0) ? e.d0 : ((k / 4) == 7) ? e.dl : 7'b1111111;
            if (cathode !== exp_c) begin
              if ((k / 4) == 0) d0_seen = cathode;
              else if ((k / 4) == 7) dl_seen = cathode;
              else mid_bad++;
            end
          end
          if (k < 31) @(negedge clock);
        end
        checkOutput($sformatf("frame%0d_anode_errors", f), 32'(an_bad), 32'h0);
        checkOutput($sformatf("frame%0d_frame_start_errors", f), 32'(fs_bad), 32'h0);
        checkOutput($sformatf("frame%0d_digit0", f), 32'(d0_seen), 32'(e.d0));
        checkOutput($sformatf("frame%0d_digit7", f), 32'(dl_seen), 32'(e.dl));
        checkOutput($sformatf("frame%0d_middle_errors", f), 32'(mid_bad), 32'h0);
        @(negedge clock);
      end
    end
    mon_done = 1'b1;
  end

  initial begin : monitor_b
    logic [3:0] exp_an;
    logic [6:0] exp_c;
    int an_bad;
    int fs_bad;
    int c_bad;
    int guard;
    wait (scan_go);
    guard = 0;
    @(negedge clock);
    while (!frame_start_b && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (!frame_start_b) begin
      checkOutput("b_first_frame_start", 32'h0, 32'h1);
    end else begin
      for (int f = 0; f < 3; f++) begin
        an_bad = 0;
        fs_bad = 0;
        c_bad = 0;
        for (int k = 0; k < 16; k++) begin
          exp_an = ((k % 4) < 1) ? 4'hF : ~(4'h1 << (k / 4));
          if (anode_b !== exp_an) an_bad++;
          if (frame_start_b !== (k == 0)) fs_bad++;
          if ((k % 4) >= 1) begin
            exp_c = ((k / 4) == 0) ? 7'b0000000 : ((k / 4) == 3) ? 7'b0011000 : 7'b1111111;
            if (cathode_b !== exp_c) c_bad++;
          end
          if (k < 15) @(negedge clock);
        end
        checkOutput($sformatf("b_frame%0d_anode_errors", f), 32'(an_bad), 32'h0);
        checkOutput($sformatf("b_frame%0d_frame_start_errors", f), 32'(fs_bad), 32'h0);
        checkOutput($sformatf("b_frame%0d_cathode_errors", f), 32'(c_bad), 32'h0);
        @(negedge clock);
      end
    end
    mon_b_done = 1'b1;
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d failures %0d", checks, fails);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
